// File: rtl/ahb_sram_pkg.sv
// Shared types and helpers for the AHB-lite SRAM slave.
package ahb_sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ERR1 = 2'd2,
    ERR2 = 2'd3
  } slave_state_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Unsigned window check; 33-bit math so a window ending at 4 GiB cannot wrap.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] depth);
    logic [32:0] last;
    last = 33'(base) + (33'(depth) << 2) - 33'd1;
    return (33'(addr) >= 33'(base)) && (33'(addr) <= last);
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// 1R1W synchronous word array with registered read; a write wins on address collision.
module ahb_sram_array #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register; forwards write data when both ports hit the same word.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-lite slave in front of a synchronous SRAM with programmable wait states.
// Optional macro AHB_SRAM_PARITY_EN adds a per-word even-parity bit; a read
// with bad parity answers ERROR while hrdata_o still shows the raw word.
module ahb_sram_slave
  import ahb_sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] IDLE_ADDR   = 32'hFFFF_FFFF
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] haddr_i,
  input  logic                  hwrite_i,
  input  logic [DATA_WIDTH-1:0] hwdata_i,
  output logic [DATA_WIDTH-1:0] hrdata_o,
  output logic                  hready_o,
  output logic                  hresp_o
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
`ifdef AHB_SRAM_PARITY_EN
  localparam int unsigned MEM_W = DATA_WIDTH + 1;
`else
  localparam int unsigned MEM_W = DATA_WIDTH;
`endif

  slave_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             write_q, write_d;

  logic             rd_en_c;
  logic             wr_en_c;
  logic [MEM_W-1:0] rd_data;
  logic [MEM_W-1:0] wr_data;
  logic             par_err_c;
  logic [AW-1:0]    idx_c;
  logic             ok_c;

  // Word index and legality of the address currently on the bus.
  assign idx_c = AW'((32'(haddr_i) - BASE_ADDR) >> 2);
  assign ok_c  = in_window(32'(haddr_i), BASE_ADDR, 32'(DEPTH_WORDS)) &&
                 (haddr_i[1:0] == 2'b00);

`ifdef AHB_SRAM_PARITY_EN
  // Even parity: stored bit makes the XOR of the whole word zero.
  assign wr_data   = {^hwdata_i, hwdata_i};
  assign par_err_c = ^rd_data;
`else
  assign wr_data   = hwdata_i;
  assign par_err_c = 1'b0;
`endif

  assign hrdata_o = rd_data[DATA_WIDTH-1:0];

  ahb_sram_array #(
    .WIDTH (MEM_W),
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_array (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .rd_en   (rd_en_c),
    .rd_addr (idx_c),
    .rd_data (rd_data),
    .wr_en   (wr_en_c),
    .wr_addr (addr_q),
    .wr_data (wr_data)
  );

  // State, wait counter and latched address-phase attributes.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
    end
  end

  // Next state, SRAM strobes and bus response, decoded from the registered state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    write_d  = write_q;
    rd_en_c  = 1'b0;
    wr_en_c  = 1'b0;
    hready_o = 1'b1;
    hresp_o  = HRESP_OKAY;
    case (state_q)
      IDLE: begin
        if (32'(haddr_i) != IDLE_ADDR) begin
          addr_d  = idx_c;
          write_d = hwrite_i;
          if (ok_c) begin
            rd_en_c = 1'b1;
            cnt_d   = CNT_W'(WAIT_STATES);
            state_d = DATA;
          end else begin
            state_d = ERR1;
          end
        end
      end
      DATA: begin
        hready_o = (cnt_q == '0);
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (write_q) begin
          wr_en_c = 1'b1;
          state_d = IDLE;
        end else if (par_err_c) begin
          // Parity failure turns this cycle into the first error cycle.
          hready_o = 1'b0;
          hresp_o  = HRESP_ERROR;
          state_d  = ERR2;
        end else begin
          state_d = IDLE;
        end
      end
      ERR1: begin
        hready_o = 1'b0;
        hresp_o  = HRESP_ERROR;
        state_d  = ERR2;
      end
      ERR2: begin
        hresp_o = HRESP_ERROR;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench: dut0 with no wait states, dut1 with two wait states.
module tb_ahb_sram_slave;

  localparam logic [31:0] IDLE_A = 32'hFFFF_FFFF;

  typedef struct {
    int unsigned issue;
    logic        resp;
    logic [31:0] rdata;
    logic        chk;
    int unsigned lat;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0][31:0]  haddr;
  logic [1:0][31:0]  hwdata;
  logic [1:0][31:0]  hrdata;
  logic [1:0]        hwrite;
  logic [1:0]        hready;
  logic [1:0]        hresp;

  exp_t        q0[$];
  exp_t        q1[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  ahb_sram_slave #(.WAIT_STATES(0)) dut0 (
    .clk_i(clk), .reset_i(reset_n), .haddr_i(haddr[0]), .hwrite_i(hwrite[0]),
    .hwdata_i(hwdata[0]), .hrdata_o(hrdata[0]), .hready_o(hready[0]), .hresp_o(hresp[0])
  );

  ahb_sram_slave #(.WAIT_STATES(2)) dut1 (
    .clk_i(clk), .reset_i(reset_n), .haddr_i(haddr[1]), .hwrite_i(hwrite[1]),
    .hwdata_i(hwdata[1]), .hrdata_o(hrdata[1]), .hready_o(hready[1]), .hresp_o(hresp[1])
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: compares every response cycle (and stall cycles) against the queue head.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      exp_t e;
      logic have;
      have = 1'b0;
      if (s == 0 && q0.size() > 0) begin e = q0[0]; have = 1'b1; end
      if (s == 1 && q1.size() > 0) begin e = q1[0]; have = 1'b1; end
      if (have && cyc > e.issue) begin
        if (hready[s]) begin
          check($sformatf("dut%0d_resp", s), 32'(hresp[s]), 32'(e.resp));
          check($sformatf("dut%0d_latency", s), cyc - e.issue, e.lat);
          if (e.chk) check($sformatf("dut%0d_rdata", s), hrdata[s], e.rdata);
          if (s == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end else begin
          check($sformatf("dut%0d_stall_hresp", s), 32'(hresp[s]), 32'(e.resp));
        end
      end
    end
  end

  // One transfer; called just after a rising edge so this cycle is the address phase.
  task automatic xfer(input int s, input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input logic er, input logic [31:0] ed, input logic chk, input int unsigned lat);
    exp_t e;
    int   qs;
    haddr[s]  = a;
    hwrite[s] = w;
    hwdata[s] = wd;
    e.issue = cyc; e.resp = er; e.rdata = ed; e.chk = chk; e.lat = lat;
    if (s == 0) q0.push_back(e); else q1.push_back(e);
    qs = 1;
    for (int i = 0; i < 20 && qs != 0; i++) begin
      @(posedge clk); #1;
      qs = (s == 0) ? q0.size() : q1.size();
    end
    if (qs != 0) begin
      check($sformatf("dut%0d_timeout", s), 32'(qs), 32'd0);
      if (s == 0) q0.delete(); else q1.delete();
    end
    haddr[s]  = IDLE_A;
    hwrite[s] = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    haddr  = {IDLE_A, IDLE_A};
    hwdata = '0;
    hwrite = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check("rst_hready", 32'(hready[s]), 32'd1);
      check("rst_hresp", 32'(hresp[s]), 32'd0);
      check("rst_hrdata", hrdata[s], 32'd0);
    end
    reset_n = 1'b1;
    idle_cycle();

    // Basic write/read, back-to-back, no wait states.
    xfer(0, 32'h0000_0000, 1'b1, 32'h1111_0000, 1'b0, 32'h0, 1'b0, 1);
    xfer(0, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 1);
    xfer(0, 32'h0000_0010, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1);
    // Last word of the window.
    xfer(0, 32'h0000_0FFC, 1'b1, 32'h7777_0FFC, 1'b0, 32'h0, 1'b0, 1);
    xfer(0, 32'h0000_0FFC, 1'b0, 32'h0, 1'b0, 32'h7777_0FFC, 1'b1, 1);
    // Out of window: read and write both error; word 0 must be untouched.
    xfer(0, 32'h0000_1000, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 2);
    xfer(0, 32'h0000_1000, 1'b1, 32'hBAD0_BAD0, 1'b1, 32'h0, 1'b0, 2);
    xfer(0, 32'h0000_0000, 1'b0, 32'h0, 1'b0, 32'h1111_0000, 1'b1, 1);
    // Misaligned, then a clean read.
    xfer(0, 32'h0000_0002, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 2);
    xfer(0, 32'h0000_0000, 1'b0, 32'h0, 1'b0, 32'h1111_0000, 1'b1, 1);
    // Read-after-write with no bubble, then overwrite.
    xfer(0, 32'h0000_0008, 1'b1, 32'hA5A5_5A5A, 1'b0, 32'h0, 1'b0, 1);
    xfer(0, 32'h0000_0008, 1'b0, 32'h0, 1'b0, 32'hA5A5_5A5A, 1'b1, 1);
    xfer(0, 32'h0000_0008, 1'b1, 32'h0F0F_F0F0, 1'b0, 32'h0, 1'b0, 1);
    xfer(0, 32'h0000_0008, 1'b0, 32'h0, 1'b0, 32'h0F0F_F0F0, 1'b1, 1);

    // Two wait states on dut1.
    xfer(1, 32'h0000_0004, 1'b1, 32'h4444_4444, 1'b0, 32'h0, 1'b0, 3);
    xfer(1, 32'h0000_0004, 1'b0, 32'h0, 1'b0, 32'h4444_4444, 1'b1, 3);
    xfer(1, 32'h0000_0006, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 2);

    // Reset in the data phase of a write drops it.
    xfer(0, 32'h0000_000C, 1'b1, 32'hCAFE_0001, 1'b0, 32'h0, 1'b0, 1);
    idle_cycle();
    haddr[0]  = 32'h0000_000C;
    hwrite[0] = 1'b1;
    hwdata[0] = 32'h0000_1234;
    @(posedge clk); #1;
    haddr[0]  = IDLE_A;
    hwrite[0] = 1'b0;
    reset_n   = 1'b0;
    #1;
    check("abort_hready", 32'(hready[0]), 32'd1);
    check("abort_hresp", 32'(hresp[0]), 32'd0);
    check("abort_hrdata", hrdata[0], 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle_cycle();
    xfer(0, 32'h0000_000C, 1'b0, 32'h0, 1'b0, 32'hCAFE_0001, 1'b1, 1);
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
